// File: rtl/noc_in_queue.sv
// Per-input-port flit FIFO with XY route computed at write; head flit visible one cycle after push, no bypass.
// Backpressure: ready_o low when full; a push with a concurrent pop is still taken, a push into a full FIFO is dropped and flagged.
module noc_in_queue #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int COORD_W = 2,
    parameter int MY_X    = 0,
    parameter int MY_Y    = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    output logic                       ready_o,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       valid_o,
    output logic [2:0]                 address_route_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);
    localparam logic [COORD_W-1:0] MY_X_C   = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY_Y_C   = COORD_W'(MY_Y);

    localparam logic [2:0] RT_N = 3'd0;
    localparam logic [2:0] RT_S = 3'd1;
    localparam logic [2:0] RT_E = 3'd2;
    localparam logic [2:0] RT_W = 3'd3;
    localparam logic [2:0] RT_L = 3'd4;

    logic [DATA_W-1:0] r_mem   [DEPTH];
    logic [2:0]        r_route [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    logic               w_valid;
    logic               w_ready;
    logic               w_push_acc;
    logic               w_pop_acc;
    logic               w_drop;
    logic [COORD_W-1:0] w_dx;
    logic [COORD_W-1:0] w_dy;
    logic [2:0]         w_route;

    assign w_valid    = (r_count != '0);
    assign w_ready    = (r_count != FULL_CNT);
    assign w_push_acc = push_i && (w_ready || pop_i);
    assign w_pop_acc  = pop_i && w_valid;
    assign w_drop     = push_i && !w_ready && !pop_i;

    assign w_dx = data_i[COORD_W-1:0];
    assign w_dy = data_i[2*COORD_W-1:COORD_W];

    // X is resolved before Y (dimension-ordered routing).
    always_comb begin
        w_route = RT_L;
        if (w_dx > MY_X_C)
            w_route = RT_E;
        else if (w_dx < MY_X_C)
            w_route = RT_W;
        else if (w_dy > MY_Y_C)
            w_route = RT_N;
        else if (w_dy < MY_Y_C)
            w_route = RT_S;
    end

    // Storage is deliberately left out of reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr]   <= data_i;
            r_route[r_wr_ptr] <= w_route;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_acc)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_acc)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    assign valid_o         = w_valid;
    assign ready_o         = w_ready;
    assign count_o         = r_count;
    assign overflow_o      = r_overflow;
    assign data_o          = w_valid ? r_mem[r_rd_ptr] : '0;
    assign address_route_o = w_valid ? r_route[r_rd_ptr] : 3'd0;

endmodule

// File: tb/tb_noc_in_queue.sv
// Directed table-driven bench for noc_in_queue at router coordinate (1,1).
module tb_noc_in_queue;

    logic        clk;
    logic        rst_n;
    logic        push_i;
    logic [31:0] data_i;
    logic        ready_o;
    logic        pop_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic [2:0]  address_route_o;
    logic [2:0]  count_o;
    logic        overflow_o;

    noc_in_queue #(
        .DATA_W (32),
        .DEPTH  (4),
        .COORD_W(2),
        .MY_X   (1),
        .MY_Y   (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .push_i         (push_i),
        .data_i         (data_i),
        .ready_o        (ready_o),
        .pop_i          (pop_i),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .address_route_o(address_route_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic        pop;
        logic [31:0] din;
        logic        valid;
        logic        ready;
        logic [2:0]  count;
        logic [31:0] dout;
        logic [2:0]  route;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic p, logic q, logic [31:0] d, logic v, logic r,
                                logic [2:0] c, logic [31:0] o, logic [2:0] rt, logic ov);
        vec_t x;
        x.push = p; x.pop = q; x.din = d; x.valid = v; x.ready = r;
        x.count = c; x.dout = o; x.route = rt; x.ovf = ov;
        return x;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic v, input logic r, input logic [2:0] c,
                           input logic [31:0] o, input logic [2:0] rt, input logic ov);
        chk("valid_o", idx, 32'(valid_o), 32'(v));
        chk("ready_o", idx, 32'(ready_o), 32'(r));
        chk("count_o", idx, 32'(count_o), 32'(c));
        chk("data_o", idx, data_o, o);
        chk("route_o", idx, 32'(address_route_o), 32'(rt));
        chk("overflow_o", idx, 32'(overflow_o), 32'(ov));
    endtask

    initial begin
        // Route encoding: 0=N 1=S 2=E 3=W 4=L; flit bits [1:0]=X, [3:2]=Y.
        vecs.push_back(mk(1, 0, 32'h0B, 1, 1, 1, 32'h0B, 2, 0));
        vecs.push_back(mk(0, 1, 32'h00, 0, 1, 0, 32'h00, 0, 0));
        vecs.push_back(mk(1, 0, 32'h04, 1, 1, 1, 32'h04, 3, 0));
        vecs.push_back(mk(1, 0, 32'h0D, 1, 1, 2, 32'h04, 3, 0));
        vecs.push_back(mk(1, 0, 32'h01, 1, 1, 3, 32'h04, 3, 0));
        vecs.push_back(mk(1, 0, 32'h05, 1, 0, 4, 32'h04, 3, 0));
        vecs.push_back(mk(0, 1, 32'h00, 1, 1, 3, 32'h0D, 0, 0));
        vecs.push_back(mk(0, 1, 32'h00, 1, 1, 2, 32'h01, 1, 0));
        vecs.push_back(mk(0, 1, 32'h00, 1, 1, 1, 32'h05, 4, 0));
        vecs.push_back(mk(0, 1, 32'h00, 0, 1, 0, 32'h00, 0, 0));
        vecs.push_back(mk(0, 1, 32'h00, 0, 1, 0, 32'h00, 0, 0));
        // full FIFO, push and pop together
        vecs.push_back(mk(1, 0, 32'h10, 1, 1, 1, 32'h10, 3, 0));
        vecs.push_back(mk(1, 0, 32'h11, 1, 1, 2, 32'h10, 3, 0));
        vecs.push_back(mk(1, 0, 32'h12, 1, 1, 3, 32'h10, 3, 0));
        vecs.push_back(mk(1, 0, 32'h13, 1, 0, 4, 32'h10, 3, 0));
        vecs.push_back(mk(1, 1, 32'h20, 1, 0, 4, 32'h11, 1, 0));
        vecs.push_back(mk(0, 1, 32'h00, 1, 1, 3, 32'h12, 2, 0));
        vecs.push_back(mk(0, 1, 32'h00, 1, 1, 2, 32'h13, 2, 0));
        vecs.push_back(mk(0, 1, 32'h00, 1, 1, 1, 32'h20, 3, 0));
        vecs.push_back(mk(0, 1, 32'h00, 0, 1, 0, 32'h00, 0, 0));
        // overflow: 0x14 dropped, flag sticks
        vecs.push_back(mk(1, 0, 32'h10, 1, 1, 1, 32'h10, 3, 0));
        vecs.push_back(mk(1, 0, 32'h11, 1, 1, 2, 32'h10, 3, 0));
        vecs.push_back(mk(1, 0, 32'h12, 1, 1, 3, 32'h10, 3, 0));
        vecs.push_back(mk(1, 0, 32'h13, 1, 0, 4, 32'h10, 3, 0));
        vecs.push_back(mk(1, 0, 32'h14, 1, 0, 4, 32'h10, 3, 1));
        vecs.push_back(mk(0, 1, 32'h00, 1, 1, 3, 32'h11, 1, 1));
        vecs.push_back(mk(0, 1, 32'h00, 1, 1, 2, 32'h12, 2, 1));
        vecs.push_back(mk(0, 1, 32'h00, 1, 1, 1, 32'h13, 2, 1));
        vecs.push_back(mk(0, 1, 32'h00, 0, 1, 0, 32'h00, 0, 1));
        // back-to-back push+pop across pointer wrap
        vecs.push_back(mk(1, 0, 32'h30, 1, 1, 1, 32'h30, 3, 1));
        vecs.push_back(mk(1, 1, 32'h31, 1, 1, 1, 32'h31, 1, 1));
        vecs.push_back(mk(1, 1, 32'h32, 1, 1, 1, 32'h32, 2, 1));
        vecs.push_back(mk(1, 1, 32'h33, 1, 1, 1, 32'h33, 2, 1));
        vecs.push_back(mk(1, 1, 32'h34, 1, 1, 1, 32'h34, 3, 1));
        vecs.push_back(mk(1, 1, 32'h35, 1, 1, 1, 32'h35, 4, 1));
        vecs.push_back(mk(1, 1, 32'h36, 1, 1, 1, 32'h36, 2, 1));
        vecs.push_back(mk(1, 1, 32'h37, 1, 1, 1, 32'h37, 2, 1));
        vecs.push_back(mk(1, 1, 32'h38, 1, 1, 1, 32'h38, 3, 1));
        vecs.push_back(mk(1, 1, 32'h39, 1, 1, 1, 32'h39, 0, 1));
        vecs.push_back(mk(1, 1, 32'h3A, 1, 1, 1, 32'h3A, 2, 1));
        vecs.push_back(mk(1, 0, 32'h3B, 1, 1, 2, 32'h3A, 2, 1));
        vecs.push_back(mk(1, 0, 32'h3C, 1, 1, 3, 32'h3A, 2, 1));

        rst_n  = 1'b0;
        push_i = 1'b0;
        pop_i  = 1'b0;
        data_i = '0;
        #1;
        chk_all(-1, 0, 1, 0, 32'h0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            push_i = vecs[i].push;
            pop_i  = vecs[i].pop;
            data_i = vecs[i].din;
            @(posedge clk);
            #1;
            chk_all(i, vecs[i].valid, vecs[i].ready, vecs[i].count,
                    vecs[i].dout, vecs[i].route, vecs[i].ovf);
        end
        push_i = 1'b0;
        pop_i  = 1'b0;
        data_i = '0;

        // Asynchronous reset with three flits buffered.
        #2;
        rst_n = 1'b0;
        #1;
        chk_all(100, 0, 1, 0, 32'h0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        pop_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk_all(101 + k, 0, 1, 0, 32'h0, 0, 0);
        end
        pop_i = 1'b0;

        push_i = 1'b1;
        data_i = 32'h07;
        #2;
        chk("no_bypass_valid", 103, 32'(valid_o), 32'h0);
        @(posedge clk);
        #1;
        push_i = 1'b0;
        data_i = '0;
        chk_all(104, 1, 1, 1, 32'h07, 2, 0);

        pop_i = 1'b1;
        @(posedge clk);
        #1;
        pop_i = 1'b0;
        chk_all(105, 0, 1, 0, 32'h0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
